// File: rtl/wb_regfile.sv
// Y86-64 architectural register file with retirement/status tracking.
// Commits the W-stage E and M writes, bypasses them to decode reads, and latches a sticky HALTED state.
module wb_regfile #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [2:0]        W_stat_i,
    input  logic [3:0]        W_icode_i,
    input  logic [3:0]        W_dstE_i,
    input  logic [DATA_W-1:0] W_valE_i,
    input  logic [3:0]        W_dstM_i,
    input  logic [DATA_W-1:0] W_valM_i,
    input  logic [3:0]        d_srcA_i,
    input  logic [3:0]        d_srcB_i,
    output logic [DATA_W-1:0] d_rvalA_o,
    output logic [DATA_W-1:0] d_rvalB_o,
    input  logic [3:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic [2:0]        cpu_stat_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_cnt_o
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    localparam logic [2:0] ST_AOK = 3'd1;
    localparam logic [2:0] ST_INS = 3'd4;

    logic [0:0]        r_state;
    logic [2:0]        r_stat;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_regs [0:14];

    logic              w_commit;
    logic              w_unused_icode;

    // icode is carried for observation only
    assign w_unused_icode = ^W_icode_i;

    assign w_commit = (r_state == S_RUN) && (W_stat_i == ST_AOK);

    // Index 15 never matches a storage slot, so "none" needs no extra qualifier.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 15; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < 15; i++) begin
                if (W_dstM_i == 4'(i))      r_regs[i] <= W_valM_i;
                else if (W_dstE_i == 4'(i)) r_regs[i] <= W_valE_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (w_commit && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_RUN;
            r_stat  <= ST_AOK;
        end else if (r_state == S_RUN) begin
            case (W_stat_i)
                3'd2, 3'd3, 3'd4: begin
                    r_state <= S_HALT;
                    r_stat  <= W_stat_i;
                end
                3'd5, 3'd6, 3'd7: begin
                    r_state <= S_HALT;
                    r_stat  <= ST_INS;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [DATA_W-1:0] f_rd(input logic [3:0] src, input logic byp);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < 15; i++)
            if (src == 4'(i)) v = r_regs[i];
        // M port outranks E port, matching the commit priority
        if (byp && src != 4'hF) begin
            if (src == W_dstM_i)      v = W_valM_i;
            else if (src == W_dstE_i) v = W_valE_i;
        end
        return v;
    endfunction

    always_comb begin
        d_rvalA_o  = f_rd(d_srcA_i, w_commit);
        d_rvalB_o  = f_rd(d_srcB_i, w_commit);
        dbg_data_o = f_rd(dbg_addr_i, 1'b0);
    end

    assign cpu_stat_o    = r_stat;
    assign halted_o      = (r_state == S_HALT);
    assign retired_cnt_o = r_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, a negedge monitor pops and compares.
module tb_wb_regfile;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [2:0]        W_stat_i;
    logic [3:0]        W_icode_i;
    logic [3:0]        W_dstE_i;
    logic [DATA_W-1:0] W_valE_i;
    logic [3:0]        W_dstM_i;
    logic [DATA_W-1:0] W_valM_i;
    logic [3:0]        d_srcA_i;
    logic [3:0]        d_srcB_i;
    logic [DATA_W-1:0] d_rvalA_o;
    logic [DATA_W-1:0] d_rvalB_o;
    logic [3:0]        dbg_addr_i;
    logic [DATA_W-1:0] dbg_data_o;
    logic [2:0]        cpu_stat_o;
    logic              halted_o;
    logic [CNT_W-1:0]  retired_cnt_o;

    wb_regfile #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .W_stat_i(W_stat_i), .W_icode_i(W_icode_i),
        .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i),
        .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i),
        .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o),
        .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o),
        .cpu_stat_o(cpu_stat_o), .halted_o(halted_o),
        .retired_cnt_o(retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int SEL_A = 0, SEL_B = 1, SEL_DBG = 2, SEL_STAT = 3, SEL_HALT = 4, SEL_CNT = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Monitor: everything queued since the last posedge is checked mid-cycle.
    always @(negedge clk_i) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = sb.pop_front();
            case (e.sel)
                SEL_A:    act = d_rvalA_o;
                SEL_B:    act = d_rvalB_o;
                SEL_DBG:  act = dbg_data_o;
                SEL_STAT: act = 64'(cpu_stat_o);
                SEL_HALT: act = 64'(halted_o);
                default:  act = 64'(retired_cnt_o);
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic expv(input string nm, input int sel, input logic [63:0] v);
        sb.push_back('{nm, sel, v});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        W_stat_i = 3'd0; W_icode_i = 4'h0;
        W_dstE_i = 4'hF; W_valE_i = '0;
        W_dstM_i = 4'hF; W_valM_i = '0;
        d_srcA_i = 4'hF; d_srcB_i = 4'hF;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm,
                         input logic [3:0] sa, input logic [3:0] sbb);
        W_stat_i = st; W_icode_i = 4'h6;
        W_dstE_i = de; W_valE_i = ve;
        W_dstM_i = dm; W_valM_i = vm;
        d_srcA_i = sa; d_srcB_i = sbb;
    endtask

    task automatic chk_reg(input string nm, input logic [3:0] r, input logic [63:0] v);
        dbg_addr_i = r;
        expv(nm, SEL_DBG, v);
        step();
    endtask

    task automatic do_reset();
        idle();
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        step();
    endtask

    initial begin
        idle();
        dbg_addr_i = 4'hF;
        rst_n_i    = 1'b0;
        step();
        step();
        expv("rst_stat", SEL_STAT, 64'd1);
        expv("rst_halt", SEL_HALT, 64'd0);
        expv("rst_cnt",  SEL_CNT,  64'd0);
        expv("rst_dbgF", SEL_DBG,  64'd0);
        rst_n_i = 1'b1;
        step();

        // Seed R3, then reset mid-cycle while another R3 write is presented.
        drive(3'd1, 4'd3, 64'h33, 4'hF, 64'h0, 4'hF, 4'hF);
        step();
        idle();
        expv("seed_cnt", SEL_CNT, 64'd1);
        chk_reg("seed_r3", 4'd3, 64'h33);
        drive(3'd1, 4'd3, 64'h44, 4'hF, 64'h0, 4'hF, 4'hF);
        dbg_addr_i = 4'd3;
        #2;
        rst_n_i = 1'b0;
        expv("t1_r3",   SEL_DBG,  64'h0);
        expv("t1_cnt",  SEL_CNT,  64'd0);
        expv("t1_stat", SEL_STAT, 64'd1);
        expv("t1_halt", SEL_HALT, 64'd0);
        step();
        idle();
        rst_n_i = 1'b1;
        step();
        chk_reg("t1_r3_after", 4'd3, 64'h0);

        // T2 dual write with bypass on both read ports
        drive(3'd1, 4'd2, 64'h11, 4'd5, 64'h22, 4'd2, 4'd5);
        expv("t2_bypA", SEL_A, 64'h11);
        expv("t2_bypB", SEL_B, 64'h22);
        step();
        idle();
        expv("t2_cnt", SEL_CNT, 64'd1);
        chk_reg("t2_r2", 4'd2, 64'h11);
        chk_reg("t2_r5", 4'd5, 64'h22);
        d_srcA_i = 4'd5; d_srcB_i = 4'd2;
        expv("t2_rdA", SEL_A, 64'h22);
        expv("t2_rdB", SEL_B, 64'h11);
        step();
        idle();

        // T3 same destination: M port wins
        drive(3'd1, 4'd4, 64'hAA, 4'd4, 64'hBB, 4'd4, 4'hF);
        expv("t3_bypA", SEL_A, 64'hBB);
        step();
        idle();
        expv("t3_cnt", SEL_CNT, 64'd2);
        chk_reg("t3_r4", 4'd4, 64'hBB);

        // T4 bubble, then AOK with no destinations
        drive(3'd0, 4'd1, 64'h5, 4'hF, 64'h0, 4'd1, 4'hF);
        expv("t4_bub_nobyp", SEL_A, 64'h0);
        step();
        idle();
        expv("t4_bub_cnt", SEL_CNT, 64'd2);
        chk_reg("t4_r1", 4'd1, 64'h0);
        drive(3'd1, 4'hF, 64'h9, 4'hF, 64'h8, 4'hF, 4'hF);
        expv("t4_srcF", SEL_A, 64'h0);
        step();
        idle();
        expv("t4_none_cnt", SEL_CNT, 64'd3);
        chk_reg("t4_r2_kept", 4'd2, 64'h11);

        // T5 halt: seed R6, halt, then an AOK write must be ignored
        drive(3'd1, 4'd6, 64'h66, 4'hF, 64'h0, 4'hF, 4'hF);
        step();
        drive(3'd2, 4'd6, 64'h77, 4'hF, 64'h0, 4'd6, 4'hF);
        expv("t5_hlt_nobyp", SEL_A, 64'h66);
        step();
        idle();
        expv("t5_stat", SEL_STAT, 64'd2);
        expv("t5_halt", SEL_HALT, 64'd1);
        expv("t5_cnt",  SEL_CNT,  64'd4);
        chk_reg("t5_r6", 4'd6, 64'h66);
        drive(3'd1, 4'd6, 64'h99, 4'hF, 64'h0, 4'd6, 4'hF);
        expv("t5_halted_nobyp", SEL_A, 64'h66);
        step();
        drive(3'd3, 4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'hF);
        step();
        idle();
        expv("t5_cnt_frozen",  SEL_CNT,  64'd4);
        expv("t5_stat_sticky", SEL_STAT, 64'd2);
        chk_reg("t5_r6_frozen", 4'd6, 64'h66);
        do_reset();
        expv("t5_rst_stat", SEL_STAT, 64'd1);
        expv("t5_rst_halt", SEL_HALT, 64'd0);
        step();

        // ADR status is reported verbatim
        drive(3'd3, 4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'hF);
        step();
        idle();
        expv("adr_stat", SEL_STAT, 64'd3);
        step();
        do_reset();

        // T6 illegal status maps to INS
        drive(3'd7, 4'd1, 64'h1, 4'hF, 64'h0, 4'hF, 4'hF);
        step();
        idle();
        expv("t6_ill_stat", SEL_STAT, 64'd4);
        expv("t6_ill_halt", SEL_HALT, 64'd1);
        step();
        do_reset();

        // T6 saturation: 20 retirements into a 4-bit counter
        for (int i = 1; i <= 20; i++) begin
            drive(3'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'hF);
            step();
            expv($sformatf("t6_cnt_%0d", i), SEL_CNT, 64'((i > 15) ? 15 : i));
        end
        idle();
        step();

        @(negedge clk_i);
        #1;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
